// File: rtl/dmc_output_if.sv
// Sample-buffer fill handshake between the DMC memory reader and the output unit.
interface dmc_output_if;
    logic       buf_valid;
    logic [7:0] buf_data;
    logic       buf_ready;

    modport master (output buf_valid, output buf_data, input  buf_ready);
    modport slave  (input  buf_valid, input  buf_data, output buf_ready);
endinterface

// File: rtl/dmc_output_unit.sv
// DMC output stage: one-byte sample buffer, LSB-first shifter and 7-bit delta level
// with $4011 direct load. All state advances only on cpu_en.
module dmc_output_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic        next_step,
    input  logic        direct_load,
    input  logic [6:0]  direct_value,
    dmc_output_if.slave bus,
    output logic [6:0]  level,
    output logic        silence,
    output logic        cycle_start
);
    logic [7:0] shift;
    logic [7:0] buffer;
    logic [3:0] bits_remaining;
    logic       buf_full;
    logic [6:0] level_stepped;
    logic       fill;

    assign bus.buf_ready = ~buf_full;
    assign fill          = cpu_en & bus.buf_valid & ~buf_full;

    // Delta adjust saturates: 126/127 never go up, 0/1 never go down.
    always_comb begin
        level_stepped = level;
        if (!silence && shift[0] && level <= 7'd125)
            level_stepped = level + 7'd2;
        else if (!silence && !shift[0] && level >= 7'd2)
            level_stepped = level - 7'd2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level          <= 7'd0;
            shift          <= 8'h00;
            buffer         <= 8'h00;
            bits_remaining <= 4'd8;
            silence        <= 1'b1;
            buf_full       <= 1'b0;
            cycle_start    <= 1'b0;
        end else begin
            cycle_start <= 1'b0;
            if (fill) begin
                buffer   <= bus.buf_data;
                buf_full <= 1'b1;
            end
            if (cpu_en && direct_load)
                level <= direct_value;
            else if (cpu_en && next_step)
                level <= level_stepped;
            if (cpu_en && next_step) begin
                shift <= {1'b0, shift[7:1]};
                if (bits_remaining > 4'd1) begin
                    bits_remaining <= bits_remaining - 4'd1;
                end else begin
                    bits_remaining <= 4'd8;
                    cycle_start    <= 1'b1;
                    // fill only happens when buf_full=0, so this never races the load above
                    if (buf_full) begin
                        shift    <= buffer;
                        silence  <= 1'b0;
                        buf_full <= 1'b0;
                    end else begin
                        silence  <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: doc/dmc_output_unit.md
Name: dmc_output_unit

Overview:
- DMC output stage of the APU, directly downstream of the DMC rate timer; it consumes the timer's `next_step` strobe.
- Holds a one-byte sample buffer, filled by the DMC memory reader through a valid/ready handshake.
- Shifts the sample out LSB-first, one bit per step, and moves a 7-bit delta level up or down by 2 per bit.
- Also supports the $4011 direct level load. The level feeds the channel mixer.

Parameters:
- None. Level width is fixed at 7; bits per sample are fixed at 8.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cpu_en  input  1  CPU-rate clock enable; all state updates qualified by it
- next_step  input  1  step strobe from the DMC rate timer; acts only when cpu_en=1
- direct_load  input  1  $4011 write strobe; acts only when cpu_en=1
- direct_value  input  7  new level value for a $4011 write
- buf_valid  input  1  memory reader offers a sample byte
- buf_data  input  8  sample byte
- buf_ready  output  1  sample buffer empty (combinational: equals ~buf_full)
- level  output  7  current delta level to the mixer
- silence  output  1  current 8-bit output cycle is silent
- cycle_start  output  1  one-cycle pulse when a new 8-bit output cycle begins

Behaviour:
- Reset (clk edge with reset=1, regardless of cpu_en):
  - level=0, shift=0x00, bits_remaining=8, silence=1, buf_full=0, cycle_start=0.
  - buf_ready therefore reads 1 after reset.
- Buffer fill:
  - Condition: cpu_en & buf_valid & buf_ready.
  - Effect: buffer<=buf_data, buf_full<=1.
  - Upstream must hold buf_valid/buf_data until accepted.
- Step (cpu_en & next_step), in this order of effect, all on the same edge:
  1. If silence=0 and shift[0]=1 and level<=125: level+=2.
  2. If silence=0 and shift[0]=0 and level>=2: level-=2.
  3. Saturation: otherwise level is unchanged (no wrap; 126/127 never increment, 0/1 never decrement).
  4. shift>>=1, zero-filled from the MSB.
  5. If bits_remaining>1: bits_remaining-=1.
  6. If bits_remaining==1: start a new cycle.
- New cycle:
  - bits_remaining<=8 and cycle_start pulses on the next cycle.
  - If buf_full: shift<=buffer, silence<=0, buf_full<=0.
  - Else: silence<=1, and the shift content is irrelevant.
- Direct load (cpu_en & direct_load): level<=direct_value.
  - Takes priority over the step adjustment in the same cycle.
  - Shift, bits_remaining and buffer still advance normally.
- Simultaneous buffer fill and cycle start with the buffer empty:
  - The new cycle sees the buffer as empty and becomes silent.
  - The fill still completes (buf_full=1 afterward).
  - The byte is used at the next cycle start.
- With the buffer full, buf_ready=0, so fill and consume never collide.
- cpu_en=0: all state frozen; cycle_start is forced to 0.
- cycle_start is registered: high for exactly one clk cycle following the edge that started the cycle.
- Reset asserted mid-cycle: an unconsumed buffer byte is discarded. The unit resumes silent with 8 bits remaining.
- Latency: level changes become visible on the clk edge where the step is taken (registered output).

Test Plan:
- Reset, then 8 steps with no buffer data:
  - level stays 0, silence=1 throughout.
  - cycle_start pulses once, after the 8th step.
  - buf_ready=1.
- Direct load 64 (0x40), then fill 0xFF:
  - After the first cycle_start: silence=0, buf_ready=1.
  - 8 steps raise level 64→80 in steps of 2.
- Saturation:
  - Direct load 126, buffer 0xFF → level stays 126 across all 8 steps.
  - Direct load 1, buffer 0x00 → level stays 1.
- Pattern 0x55 from level 64: level sequence 66,64,66,64,66,64,66,64.
- Direct load 10 coincident with a step whose bit is 1 → level=10 (not 12); the next bit is still applied on the next step.
- Fill offered on the same edge as a cycle start with the buffer empty:
  - That cycle is silent; buf_full=1.
  - The next cycle plays the byte.
- Reset mid-cycle with the buffer full: buf_ready=1, silence=1, level=0 after reset.
